// File: rtl/wb_trace_checker_if.sv
// rtl/wb_trace_checker_if.sv - write-back debug trace bundle (CPU is master, checker is slave)
interface wb_trace_checker_if;
  logic        wb_have_inst;
  logic [31:0] wb_pc;
  logic        wb_ena;
  logic [4:0]  wb_reg;
  logic [31:0] wb_value;

  modport master (
    output wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value
  );

  modport slave (
    input wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value
  );
endinterface

// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - in-order comparison of the commit trace against a golden ROM
module wb_trace_checker #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_trace_checker_if.slave    trace,
  output logic [AW-1:0]        gold_addr,
  input  logic [31:0]          gold_pc,
  input  logic                 gold_ena,
  input  logic [4:0]           gold_reg,
  input  logic [31:0]          gold_value,
  input  logic [AW:0]          gold_len,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [2:0]           err_code,
  output logic [AW-1:0]        err_index,
  output logic [31:0]          err_pc,
  output logic [31:0]          commit_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  localparam logic [2:0]  ERR_NONE    = 3'd0;
  localparam logic [2:0]  ERR_PC      = 3'd1;
  localparam logic [2:0]  ERR_ENA     = 3'd2;
  localparam logic [2:0]  ERR_REG     = 3'd3;
  localparam logic [2:0]  ERR_VALUE   = 3'd4;
  localparam logic [2:0]  ERR_TIMEOUT = 3'd5;
  localparam logic [31:0] IDLE_LAST   = 32'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [31:0]   idle_q, idle_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [AW-1:0] err_index_q, err_index_d;
  logic [31:0]   err_pc_q, err_pc_d;

  logic          dut_weff;
  logic          gold_weff;
  logic [2:0]    mis_code;
  logic [AW:0]   idx_inc;

  // Writes to x0 are architecturally invisible, so they never count as writes.
  assign dut_weff  = trace.wb_ena && (trace.wb_reg != 5'd0);
  assign gold_weff = gold_ena && (gold_reg != 5'd0);
  assign idx_inc   = idx_q + 1'b1;

  // Classify a commit against the golden entry, first differing field wins.
  always_comb begin
    mis_code = ERR_NONE;
    if (trace.wb_pc != gold_pc) begin
      mis_code = ERR_PC;
    end else if (dut_weff != gold_weff) begin
      mis_code = ERR_ENA;
    end else if (dut_weff && (trace.wb_reg != gold_reg)) begin
      mis_code = ERR_REG;
    end else if (dut_weff && (trace.wb_value != gold_value)) begin
      mis_code = ERR_VALUE;
    end
  end

  // Next-state: advance on matches, latch the first error, watch for a hang.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idle_d      = idle_q;
    cnt_d       = cnt_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    err_pc_d    = err_pc_q;
    if (state_q == S_RUN) begin
      if (idx_q >= gold_len) begin
        // Only reachable with an empty golden trace.
        state_d = S_PASS;
      end else if (trace.wb_have_inst) begin
        idle_d = 32'd0;
        if (mis_code != ERR_NONE) begin
          state_d     = S_FAIL;
          err_code_d  = mis_code;
          err_index_d = idx_q[AW-1:0];
          err_pc_d    = trace.wb_pc;
        end else begin
          idx_d = idx_inc;
          cnt_d = cnt_q + 32'd1;
          if (idx_inc == gold_len) begin
            state_d = S_PASS;
          end
        end
      end else if (idle_q == IDLE_LAST) begin
        state_d     = S_FAIL;
        err_code_d  = ERR_TIMEOUT;
        err_index_d = idx_q[AW-1:0];
        err_pc_d    = 32'd0;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end
  end

  // State and result registers; reset restarts checking from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      idx_q       <= '0;
      idle_q      <= 32'd0;
      cnt_q       <= 32'd0;
      err_code_q  <= ERR_NONE;
      err_index_q <= '0;
      err_pc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      idle_q      <= idle_d;
      cnt_q       <= cnt_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign gold_addr  = idx_q[AW-1:0];
  assign pass       = (state_q == S_PASS);
  assign fail       = (state_q == S_FAIL);
  assign done       = pass | fail;
  assign err_code   = err_code_q;
  assign err_index  = err_index_q;
  assign err_pc     = err_pc_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb/tb_wb_trace_checker.sv - directed bench for wb_trace_checker
module tb_wb_trace_checker;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_trace_checker_if tr();

  logic [AW-1:0] gold_addr;
  logic [31:0]   gold_pc, gold_value;
  logic          gold_ena;
  logic [4:0]    gold_reg;
  logic [AW:0]   gold_len;
  logic          done, pass, fail;
  logic [2:0]    err_code;
  logic [AW-1:0] err_index;
  logic [31:0]   err_pc, commit_cnt;

  logic [31:0] rom_pc    [16];
  logic        rom_ena   [16];
  logic [4:0]  rom_reg   [16];
  logic [31:0] rom_value [16];

  assign gold_pc    = rom_pc[gold_addr];
  assign gold_ena   = rom_ena[gold_addr];
  assign gold_reg   = rom_reg[gold_addr];
  assign gold_value = rom_value[gold_addr];

  int total = 0;
  int bad = 0;

  wb_trace_checker #(.AW(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .trace(tr.slave),
    .gold_addr(gold_addr), .gold_pc(gold_pc), .gold_ena(gold_ena),
    .gold_reg(gold_reg), .gold_value(gold_value), .gold_len(gold_len),
    .done(done), .pass(pass), .fail(fail), .err_code(err_code),
    .err_index(err_index), .err_pc(err_pc), .commit_cnt(commit_cnt)
  );

  task automatic set_entry(input int i, input logic [31:0] pc, input logic ena,
                           input logic [4:0] rd, input logic [31:0] val);
    rom_pc[i] = pc; rom_ena[i] = ena; rom_reg[i] = rd; rom_value[i] = val;
  endtask

  task automatic load_default_rom();
    for (int i = 0; i < 16; i++) set_entry(i, 32'hDEAD_0000, 1'b0, 5'd0, 32'd0);
    set_entry(0, 32'h0000_0000, 1'b1, 5'd1, 32'h0000_0011);
    set_entry(1, 32'h0000_0004, 1'b1, 5'd2, 32'h0000_0022);
    set_entry(2, 32'h0000_0008, 1'b0, 5'd0, 32'h0000_0000);
    set_entry(3, 32'h0000_000C, 1'b1, 5'd3, 32'h0000_0033);
  endtask

  task automatic do_reset(input logic [AW:0] len);
    @(negedge clk);
    rst_n = 1'b0;
    tr.wb_have_inst = 1'b0;
    gold_len = len;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock with the given trace inputs; returns 1 time unit after the edge.
  task automatic drive(input logic have, input logic [31:0] pc, input logic ena,
                       input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    tr.wb_have_inst = have; tr.wb_pc = pc; tr.wb_ena = ena;
    tr.wb_reg = rd; tr.wb_value = val;
    @(posedge clk);
    #1;
    tr.wb_have_inst = 1'b0;
  endtask

  task automatic commit_entry(input int i);
    drive(1'b1, rom_pc[i], rom_ena[i], rom_reg[i], rom_value[i]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    load_default_rom();
    do_reset(5'd3);
    total++; if (done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL reset_verdict got done=%b pass=%b fail=%b exp 0 0 0", done, pass, fail); end
    total++; if (err_code !== 3'd0 || err_index !== 4'd0 || err_pc !== 32'd0) begin bad++; $display("FAIL reset_err got code=%0d idx=%0d pc=%h exp 0 0 0", err_code, err_index, err_pc); end
    total++; if (commit_cnt !== 32'd0 || gold_addr !== 4'd0) begin bad++; $display("FAIL reset_cnt got cnt=%0d addr=%0d exp 0 0", commit_cnt, gold_addr); end
  endtask

  task automatic test_match();
    load_default_rom();
    do_reset(5'd3);
    commit_entry(0);
    commit_entry(1);
    total++; if (pass !== 1'b0 || gold_addr !== 4'd2 || commit_cnt !== 32'd2) begin bad++; $display("FAIL match_mid got pass=%b addr=%0d cnt=%0d exp 0 2 2", pass, gold_addr, commit_cnt); end
    commit_entry(2);
    total++; if (pass !== 1'b1 || fail !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL match_pass got pass=%b fail=%b done=%b exp 1 0 1", pass, fail, done); end
    total++; if (commit_cnt !== 32'd3 || err_code !== 3'd0) begin bad++; $display("FAIL match_cnt got cnt=%0d code=%0d exp 3 0", commit_cnt, err_code); end
    commit_entry(3);
    total++; if (pass !== 1'b1 || commit_cnt !== 32'd3) begin bad++; $display("FAIL match_terminal got pass=%b cnt=%0d exp 1 3", pass, commit_cnt); end
  endtask

  task automatic test_pc_mismatch();
    load_default_rom();
    do_reset(5'd3);
    commit_entry(0);
    drive(1'b1, 32'h0000_0008, 1'b1, 5'd2, 32'h0000_0022);
    total++; if (fail !== 1'b1 || pass !== 1'b0 || err_code !== 3'd1) begin bad++; $display("FAIL pc_verdict got fail=%b pass=%b code=%0d exp 1 0 1", fail, pass, err_code); end
    total++; if (err_index !== 4'd1 || err_pc !== 32'h0000_0008 || commit_cnt !== 32'd1) begin bad++; $display("FAIL pc_err got idx=%0d pc=%h cnt=%0d exp 1 00000008 1", err_index, err_pc, commit_cnt); end
    commit_entry(1);
    total++; if (fail !== 1'b1 || commit_cnt !== 32'd1 || err_code !== 3'd1) begin bad++; $display("FAIL pc_terminal got fail=%b cnt=%0d code=%0d exp 1 1 1", fail, commit_cnt, err_code); end
  endtask

  task automatic test_ena_x0();
    load_default_rom();
    set_entry(0, 32'h0000_0100, 1'b1, 5'd0, 32'h0000_0055);
    set_entry(1, 32'h0000_0104, 1'b1, 5'd5, 32'h0000_0007);
    do_reset(5'd2);
    drive(1'b1, 32'h0000_0100, 1'b0, 5'd0, 32'h0000_0000);
    total++; if (fail !== 1'b0 || commit_cnt !== 32'd1) begin bad++; $display("FAIL x0_match got fail=%b cnt=%0d exp 0 1", fail, commit_cnt); end
    drive(1'b1, 32'h0000_0104, 1'b0, 5'd5, 32'h0000_0007);
    total++; if (fail !== 1'b1 || err_code !== 3'd2 || err_index !== 4'd1 || err_pc !== 32'h0000_0104) begin bad++; $display("FAIL ena_err got fail=%b code=%0d idx=%0d pc=%h exp 1 2 1 00000104", fail, err_code, err_index, err_pc); end
  endtask

  task automatic test_priority();
    load_default_rom();
    set_entry(0, 32'h0000_0200, 1'b1, 5'd5, 32'h0000_0002);
    do_reset(5'd1);
    drive(1'b1, 32'h0000_0200, 1'b1, 5'd6, 32'h0000_0001);
    total++; if (fail !== 1'b1 || err_code !== 3'd3 || err_index !== 4'd0) begin bad++; $display("FAIL prio_reg got fail=%b code=%0d idx=%0d exp 1 3 0", fail, err_code, err_index); end
    do_reset(5'd1);
    drive(1'b1, 32'h0000_0200, 1'b1, 5'd5, 32'h0000_0001);
    total++; if (fail !== 1'b1 || err_code !== 3'd4 || err_pc !== 32'h0000_0200) begin bad++; $display("FAIL prio_value got fail=%b code=%0d pc=%h exp 1 4 00000200", fail, err_code, err_pc); end
  endtask

  task automatic test_timeout();
    load_default_rom();
    do_reset(5'd4);
    commit_entry(0);
    commit_entry(1);
    idle(7);
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL to_early got fail=%b exp 0", fail); end
    idle(1);
    total++; if (fail !== 1'b1 || err_code !== 3'd5 || err_index !== 4'd2 || err_pc !== 32'd0) begin bad++; $display("FAIL to_fire got fail=%b code=%0d idx=%0d pc=%h exp 1 5 2 0", fail, err_code, err_index, err_pc); end
    total++; if (commit_cnt !== 32'd2) begin bad++; $display("FAIL to_cnt got %0d exp 2", commit_cnt); end
    do_reset(5'd4);
    commit_entry(0);
    commit_entry(1);
    idle(7);
    commit_entry(2);
    total++; if (fail !== 1'b0 || commit_cnt !== 32'd3) begin bad++; $display("FAIL to_commit_wins got fail=%b cnt=%0d exp 0 3", fail, commit_cnt); end
    idle(7);
    commit_entry(3);
    total++; if (pass !== 1'b1 || fail !== 1'b0 || commit_cnt !== 32'd4) begin bad++; $display("FAIL to_then_pass got pass=%b fail=%b cnt=%0d exp 1 0 4", pass, fail, commit_cnt); end
  endtask

  task automatic test_mid_reset();
    load_default_rom();
    do_reset(5'd4);
    commit_entry(0);
    commit_entry(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (commit_cnt !== 32'd0 || gold_addr !== 4'd0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset got cnt=%0d addr=%0d done=%b exp 0 0 0", commit_cnt, gold_addr, done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) commit_entry(i);
    total++; if (pass !== 1'b1 || commit_cnt !== 32'd4 || err_code !== 3'd0) begin bad++; $display("FAIL mid_rerun got pass=%b cnt=%0d code=%0d exp 1 4 0", pass, commit_cnt, err_code); end
  endtask

  task automatic test_empty_trace();
    load_default_rom();
    do_reset(5'd0);
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL empty_pre got pass=%b exp 0", pass); end
    idle(1);
    total++; if (pass !== 1'b1 || fail !== 1'b0 || commit_cnt !== 32'd0) begin bad++; $display("FAIL empty_pass got pass=%b fail=%b cnt=%0d exp 1 0 0", pass, fail, commit_cnt); end
  endtask

  initial begin
    tr.wb_have_inst = 1'b0; tr.wb_pc = 32'd0; tr.wb_ena = 1'b0;
    tr.wb_reg = 5'd0; tr.wb_value = 32'd0;
    gold_len = '0;
    test_reset();
    test_match();
    test_pc_mismatch();
    test_ena_x0();
    test_priority();
    test_timeout();
    test_mid_reset();
    test_empty_trace();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
